delay_line_ctrl: RTL and testbench
==================================

# delay_line_ctrl

- Circular-buffer controller for the audio delay effect.
- Owns one `xilinx_true_dual_port_read_first_1_clock_ram` instance:
  - port A writes incoming samples;
  - port B reads the sample written `delay` samples earlier.
- Zeroes the buffer after reset and on flush requests.
- Sits between the sample-rate mixer output and the effect wet/dry stage.

## Interface

Parameters:
- SAMPLE_WIDTH, 16, signed sample width.
- DEPTH, 4096, buffer entries. Must be a power of two, ≥ 4.
- ADDR_WIDTH, localparam, $clog2(DEPTH).

Ports:
- clka  input  1  system clock.
- rst_n  input  1  reset. Asynchronous, active-low.
- sample_in_valid  input  1  single-cycle strobe: sample_in is valid.
- sample_in  input  SAMPLE_WIDTH  signed input sample.
- delay_in  input  ADDR_WIDTH  delay in samples. Sampled on each accepted sample.
- flush_in  input  1  single-cycle request to clear the buffer.
- sample_out  output  SAMPLE_WIDTH  signed delayed sample. Registered; holds its value between valids.
- sample_out_valid  output  1  single-cycle strobe.
- busy_out  output  1  high while clearing.
- drop_out  output  1  single-cycle pulse: an input sample was discarded.

## Operation

States: CLEAR, RUN.

Reset state:
- State CLEAR; clr_ptr = 0; wr_ptr = 0.
- Outputs: sample_out = 0, sample_out_valid = 0, busy_out = 1, drop_out = 0.

CLEAR:
- Each cycle: port A writes 0 at clr_ptr, then clr_ptr increments.
- The cycle that writes clr_ptr == DEPTH-1 transitions to RUN.
- busy_out is registered, equal to (state == CLEAR).
- sample_in_valid in CLEAR: sample discarded, drop_out = 1 next cycle.
- flush_in in CLEAR: clr_ptr restarts at 0.

RUN, on sample_in_valid:
- d_eff = (delay_in == 0) ? 1 : delay_in.
- Port A writes sample_in at wr_ptr.
- Port B reads at rd_addr = (wr_ptr − d_eff) mod DEPTH, i.e. ADDR_WIDTH-bit wrapping subtract.
- wr_ptr increments with natural wrap at DEPTH.
- Port addresses always differ (d_eff ≥ 1), so there is no same-address collision.
- Back-to-back valids, one per cycle, are fully supported. No backpressure.

Flush:
- flush_in in RUN → CLEAR; clr_ptr = 0, wr_ptr = 0.
- The valid pipeline is cleared, so in-flight reads never produce sample_out_valid. sample_out keeps its last value.
- flush_in and sample_in_valid in the same cycle: flush wins, sample dropped, drop_out pulses.

Delay changes:
- Take effect on the next accepted sample. No interpolation.
- Output may jump; this is accepted behaviour.

## Timing

- Accept at cycle N (RUN, valid, no flush) → sample_out_valid high in cycle N+3 with the read data:
  - RAM register: N+1;
  - RAM output register (HIGH_PERFORMANCE, regceb = 1): N+2;
  - sample_out register: N+3.
- Valid pipeline: 3-stage shift register, asynchronously reset to 0.
- Clear time:
  - After rst_n deasserts, busy_out stays high for exactly DEPTH cycles.
  - The first sample can be accepted in cycle DEPTH.
  - Same duration after a flush, counted from the cycle after the flush_in cycle.
- rst_n asserted mid-operation: all outputs reach their reset values immediately (asynchronous); the clear sweep restarts on release.
- RAM wiring:
  - RAM contents are not reset by rst_n; the sweep provides zeroing.
  - RAM rsta/rstb tied 0.
  - ena/enb are driven from controller strobes.

## Structure

- All logic lives in one module.
- The single sub-module is the dual-port RAM, instantiated with:
  - RAM_WIDTH = SAMPLE_WIDTH, RAM_DEPTH = DEPTH;
  - RAM_PERFORMANCE = "HIGH_PERFORMANCE", INIT_FILE = "".
- Shared package `delay_pkg` holds:
  - the state enum (CLEAR, RUN);
  - the RAM_READ_LATENCY = 2 constant;
  - OUT_LATENCY = 3.
- No other typedefs.

## Test plan

Benches use DEPTH = 16, SAMPLE_WIDTH = 16.

- **Reset sweep:** release rst_n → busy_out high for exactly 16 cycles; no sample_out_valid; sample_out = 0.
- **Basic delay:** delay_in = 4; feed 1..10 back-to-back → outputs 0,0,0,0,1,2,3,4,5,6, each valid exactly 3 cycles after its input.
- **Wrap-around:** delay_in = 15; feed 40 samples k = 1..40 → output k equals input k−15 for k > 15, else 0.
- **Delay 0:** delay_in = 0; feed 5,6,7 → outputs 0,5,6. Behaves as delay 1.
- **Flush mid-stream:**
  - Setup: delay_in = 2; feed 10 samples; assert flush_in one cycle after the 10th.
  - No further sample_out_valid.
  - busy_out high 16 cycles.
  - A sample during busy → drop_out pulse, no output.
  - After clear, feed 9,9,9 → outputs 0,0,9.
- **Async reset mid-stream:** assert rst_n low between clock edges during traffic → outputs at reset values in the same cycle; the sweep repeats after release.

Source files
------------

// File: rtl/delay_pkg.sv
// Shared definitions for the audio delay-line controller: FSM states and
// the pipeline latencies of the RAM read path.
package delay_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int RAM_READ_LATENCY = 2;
    localparam int OUT_LATENCY      = 3;

endpackage

// File: rtl/delay_line_ctrl_if.sv
// Sample/control bundle between the mixer, the delay-line controller and
// the wet/dry stage. The master side drives samples, the slave side is the
// controller.
interface delay_line_ctrl_if #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int ADDR_WIDTH   = 12
);

    logic                           sample_in_valid;
    logic signed [SAMPLE_WIDTH-1:0] sample_in;
    logic        [ADDR_WIDTH-1:0]   delay_in;
    logic                           flush_in;
    logic signed [SAMPLE_WIDTH-1:0] sample_out;
    logic                           sample_out_valid;
    logic                           busy_out;
    logic                           drop_out;

    modport master (
        output sample_in_valid, sample_in, delay_in, flush_in,
        input  sample_out, sample_out_valid, busy_out, drop_out
    );

    modport slave (
        input  sample_in_valid, sample_in, delay_in, flush_in,
        output sample_out, sample_out_valid, busy_out, drop_out
    );

endinterface

// File: rtl/xilinx_true_dual_port_read_first_1_clock_ram.sv
// Single-clock true dual-port block RAM, read-first on both ports, with an
// optional output register stage (HIGH_PERFORMANCE) controlled by regce.
module xilinx_true_dual_port_read_first_1_clock_ram #(
    parameter int    RAM_WIDTH       = 18,
    parameter int    RAM_DEPTH       = 1024,
    parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE",
    parameter string INIT_FILE       = ""
) (
    input  logic [$clog2(RAM_DEPTH)-1:0] addra,
    input  logic [$clog2(RAM_DEPTH)-1:0] addrb,
    input  logic [RAM_WIDTH-1:0]         dina,
    input  logic [RAM_WIDTH-1:0]         dinb,
    input  logic                         clka,
    input  logic                         wea,
    input  logic                         web,
    input  logic                         ena,
    input  logic                         enb,
    input  logic                         rsta,
    input  logic                         rstb,
    input  logic                         regcea,
    input  logic                         regceb,
    output logic [RAM_WIDTH-1:0]         douta,
    output logic [RAM_WIDTH-1:0]         doutb
);

    logic [RAM_WIDTH-1:0] r_bram [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] r_data_a;
    logic [RAM_WIDTH-1:0] r_data_b;

    // Both ports share one process so the array has a single driver; reads return the old word.
    always_ff @(posedge clka) begin
        if (ena) begin
            if (wea) begin
                r_bram[addra] <= dina;
            end
            r_data_a <= r_bram[addra];
        end
        if (enb) begin
            if (web) begin
                r_bram[addrb] <= dinb;
            end
            r_data_b <= r_bram[addrb];
        end
    end

    // No file preload: contents are undefined until the user writes them.
    if (INIT_FILE != "") begin : g_init_file_ignored
    end

    if (RAM_PERFORMANCE == "LOW_LATENCY") begin : g_no_out_reg
        assign douta = r_data_a;
        assign doutb = r_data_b;
    end else begin : g_out_reg
        logic [RAM_WIDTH-1:0] r_douta;
        logic [RAM_WIDTH-1:0] r_doutb;

        // Second read stage with synchronous output reset and clock enable.
        always_ff @(posedge clka) begin
            if (rsta) begin
                r_douta <= '0;
            end else if (regcea) begin
                r_douta <= r_data_a;
            end
            if (rstb) begin
                r_doutb <= '0;
            end else if (regceb) begin
                r_doutb <= r_data_b;
            end
        end

        assign douta = r_douta;
        assign doutb = r_doutb;
    end

endmodule

// File: rtl/delay_line_ctrl.sv
// Circular-buffer controller for the audio delay effect. Port A writes
// incoming samples (or zeros while sweeping), port B reads the sample
// written delay_in samples earlier; the result leaves three cycles later.
module delay_line_ctrl #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int DEPTH        = 4096
) (
    input  logic             clka,
    input  logic             rst_n,
    delay_line_ctrl_if.slave bus
);

    import delay_pkg::*;

    localparam int                    ADDR_WIDTH = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic        [ADDR_WIDTH-1:0]   r_clr_ptr;
    logic        [ADDR_WIDTH-1:0]   r_wr_ptr;
    logic        [OUT_LATENCY-1:0]  r_vld;
    logic signed [SAMPLE_WIDTH-1:0] r_sample_out;
    logic                           r_busy;
    logic                           r_drop;

    logic                           w_accept;
    logic                           w_drop;
    logic                           w_ena;
    logic                           w_wea;
    logic                           w_enb;
    logic        [ADDR_WIDTH-1:0]   w_addra;
    logic        [ADDR_WIDTH-1:0]   w_addrb;
    logic        [ADDR_WIDTH-1:0]   w_d_eff;
    logic        [SAMPLE_WIDTH-1:0] w_dina;
    logic        [SAMPLE_WIDTH-1:0] w_doutb;
    logic        [SAMPLE_WIDTH-1:0] w_unused_douta;

    // Next state and RAM strobes: sweep zeros in CLEAR, write/read one sample per accept in RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_ena       = 1'b0;
        w_wea       = 1'b0;
        w_enb       = 1'b0;
        w_addra     = r_clr_ptr;
        w_dina      = '0;
        w_d_eff     = (bus.delay_in == '0) ? ADDR_ONE : bus.delay_in;
        w_addrb     = r_wr_ptr - w_d_eff;
        w_drop      = bus.sample_in_valid && ((r_state == CLEAR) || bus.flush_in);
        case (r_state)
            CLEAR: begin
                w_ena = 1'b1;
                w_wea = 1'b1;
                if (!bus.flush_in && (r_clr_ptr == LAST_ADDR)) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (bus.flush_in) begin
                    w_state_nxt = CLEAR;
                end else if (bus.sample_in_valid) begin
                    w_accept = 1'b1;
                    w_ena    = 1'b1;
                    w_wea    = 1'b1;
                    w_enb    = 1'b1;
                    w_addra  = r_wr_ptr;
                    w_dina   = bus.sample_in;
                end
            end
            default: begin
                w_state_nxt = CLEAR;
            end
        endcase
    end

    // State register; reset always restarts the clearing sweep.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sweep and write pointers; a flush rewinds both so the buffer restarts at address 0.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_ptr <= '0;
            r_wr_ptr  <= '0;
        end else if (r_state == CLEAR) begin
            r_clr_ptr <= bus.flush_in ? '0 : r_clr_ptr + ADDR_ONE;
            r_wr_ptr  <= '0;
        end else if (bus.flush_in) begin
            r_clr_ptr <= '0;
            r_wr_ptr  <= '0;
        end else if (w_accept) begin
            r_wr_ptr <= r_wr_ptr + ADDR_ONE;
        end
    end

    // Valid pipeline tracking reads through the RAM; a flush kills every in-flight read.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
        end else if (bus.flush_in) begin
            r_vld <= '0;
        end else begin
            r_vld <= {r_vld[OUT_LATENCY-2:0], w_accept};
        end
    end

    // Output register, busy flag and drop pulse; sample_out only moves when a live read lands.
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            r_sample_out <= '0;
            r_busy       <= 1'b1;
            r_drop       <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == CLEAR);
            r_drop <= w_drop;
            if (r_vld[RAM_READ_LATENCY-1] && !bus.flush_in) begin
                r_sample_out <= w_doutb;
            end
        end
    end

    xilinx_true_dual_port_read_first_1_clock_ram #(
        .RAM_WIDTH      (SAMPLE_WIDTH),
        .RAM_DEPTH      (DEPTH),
        .RAM_PERFORMANCE("HIGH_PERFORMANCE"),
        .INIT_FILE      ("")
    ) u_ram (
        .addra (w_addra),
        .addrb (w_addrb),
        .dina  (w_dina),
        .dinb  ('0),
        .clka  (clka),
        .wea   (w_wea),
        .web   (1'b0),
        .ena   (w_ena),
        .enb   (w_enb),
        .rsta  (1'b0),
        .rstb  (1'b0),
        .regcea(1'b0),
        .regceb(1'b1),
        .douta (w_unused_douta),
        .doutb (w_doutb)
    );

    assign bus.sample_out       = r_sample_out;
    assign bus.sample_out_valid = r_vld[OUT_LATENCY-1];
    assign bus.busy_out         = r_busy;
    assign bus.drop_out         = r_drop;

endmodule

// File: tb/tb_delay_line_ctrl.sv
// Bench for delay_line_ctrl (DEPTH = 16). A behavioural model keeps the list
// of samples accepted since the last clear and a queue of outputs due three
// cycles after each accept; every cycle the DUT outputs are compared to it.
module tb_delay_line_ctrl;

    localparam int DEPTH = 16;
    localparam int SW    = 16;
    localparam int AW    = 4;

    typedef struct {
        int          due;
        logic [SW-1:0] val;
    } pend_t;

    logic clka;
    logic rst_n;

    delay_line_ctrl_if #(.SAMPLE_WIDTH(SW), .ADDR_WIDTH(AW)) bus ();

    delay_line_ctrl #(
        .SAMPLE_WIDTH(SW),
        .DEPTH       (DEPTH)
    ) dut (
        .clka (clka),
        .rst_n(rst_n),
        .bus  (bus)
    );

    pend_t         pending[$];
    logic [SW-1:0] hist[$];
    int            cycle;
    int            clearLeft;
    int            nChecks;
    int            nPass;
    logic          dropExp;
    logic [SW-1:0] lastOut;

    initial begin
        clka = 1'b0;
        forever #5 clka = ~clka;
    end

    // One comparison: counted, and reported with tag/observed/expected on failure.
    task automatic checkOutput(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
        nChecks++;
        assert (obs === exp) begin
            nPass++;
        end else begin
            $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    task automatic modelReset();
        pending.delete();
        hist.delete();
        dropExp   = 1'b0;
        lastOut   = '0;
        clearLeft = DEPTH;
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, " sample_out"}, bus.sample_out, '0);
        checkOutput({tag, " sample_out_valid"}, SW'(bus.sample_out_valid), '0);
        checkOutput({tag, " busy_out"}, SW'(bus.busy_out), SW'(1));
        checkOutput({tag, " drop_out"}, SW'(bus.drop_out), '0);
    endtask

    // Model of one clock edge: clear countdown, drops, and delayed-sample lookup.
    task automatic modelEdge(input logic v, input logic [SW-1:0] s, input logic [AW-1:0] d, input logic f);
        int            dEff;
        logic [SW-1:0] expVal;
        pend_t         p;
        dropExp = 1'b0;
        if (clearLeft > 0) begin
            dropExp = v;
            if (f) clearLeft = DEPTH;
            else   clearLeft--;
        end else if (f) begin
            dropExp = v;
            pending.delete();
            hist.delete();
            clearLeft = DEPTH;
        end else if (v) begin
            dEff   = (d == 0) ? 1 : int'(d);
            expVal = (hist.size() >= dEff) ? hist[hist.size() - dEff] : '0;
            hist.push_back(s);
            p.due = cycle + 3;
            p.val = expVal;
            pending.push_back(p);
        end
    endtask

    task automatic checkCycle();
        logic expV;
        checkOutput("busy_out", SW'(bus.busy_out), SW'(clearLeft > 0));
        checkOutput("drop_out", SW'(bus.drop_out), SW'(dropExp));
        expV = (pending.size() > 0) && (pending[0].due == cycle);
        checkOutput("sample_out_valid", SW'(bus.sample_out_valid), SW'(expV));
        if (expV) begin
            lastOut = pending[0].val;
            void'(pending.pop_front());
        end
        checkOutput("sample_out", bus.sample_out, lastOut);
    endtask

    // Drive one cycle of inputs (from a falling edge), update the model at the rising edge, check at the next falling edge.
    task automatic applyStimulus(input logic v, input logic [SW-1:0] s, input logic [AW-1:0] d, input logic f);
        bus.sample_in_valid = v;
        bus.sample_in       = s;
        bus.delay_in        = d;
        bus.flush_in        = f;
        @(posedge clka);
        modelEdge(v, s, d, f);
        cycle++;
        @(negedge clka);
        bus.sample_in_valid = 1'b0;
        bus.flush_in        = 1'b0;
        checkCycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, bus.delay_in, 1'b0);
    endtask

    task automatic flushAndWait();
        idle(4);
        applyStimulus(1'b0, '0, '0, 1'b1);
        idle(DEPTH + 1);
    endtask

    initial begin
        logic rv;
        logic rf;
        nChecks             = 0;
        nPass               = 0;
        cycle               = 0;
        rst_n               = 1'b0;
        bus.sample_in_valid = 1'b0;
        bus.sample_in       = '0;
        bus.delay_in        = '0;
        bus.flush_in        = 1'b0;
        modelReset();

        $display("[TB] reset sweep");
        #12;
        checkReset("reset");
        @(negedge clka);
        rst_n = 1'b1;
        checkOutput("busy after release", SW'(bus.busy_out), SW'(1));
        idle(20);

        $display("[TB] basic delay 4");
        for (int k = 1; k <= 10; k++) applyStimulus(1'b1, SW'(k), 4'd4, 1'b0);
        flushAndWait();

        $display("[TB] wrap-around delay 15");
        for (int k = 1; k <= 40; k++) applyStimulus(1'b1, SW'(k), 4'd15, 1'b0);
        flushAndWait();

        $display("[TB] delay 0");
        applyStimulus(1'b1, SW'(5), 4'd0, 1'b0);
        applyStimulus(1'b1, SW'(6), 4'd0, 1'b0);
        applyStimulus(1'b1, SW'(7), 4'd0, 1'b0);
        flushAndWait();

        $display("[TB] flush mid-stream");
        for (int k = 1; k <= 10; k++) applyStimulus(1'b1, SW'(16'hA000 + k), 4'd2, 1'b0);
        applyStimulus(1'b0, '0, 4'd2, 1'b1);
        idle(5);
        applyStimulus(1'b1, SW'(16'h7777), 4'd2, 1'b0);
        idle(DEPTH - 6);
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, SW'(9), 4'd2, 1'b0);
        idle(5);

        $display("[TB] async reset mid-stream");
        for (int k = 1; k <= 8; k++) applyStimulus(1'b1, SW'(16'h8100 + k), 4'd3, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkReset("async reset");
        modelReset();
        @(negedge clka);
        checkReset("held reset");
        @(negedge clka);
        rst_n = 1'b1;
        idle(DEPTH + 2);
        for (int k = 1; k <= 6; k++) applyStimulus(1'b1, SW'(16'hF000 - k), 4'd1, 1'b0);
        idle(4);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            rv = ($urandom_range(0, 99) < 65);
            rf = ($urandom_range(0, 79) == 0);
            applyStimulus(rv, SW'($urandom), AW'($urandom_range(0, 15)), rf);
        end
        idle(5);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
